// File: rtl/udp_mon_pkg.sv
// udp_mon_pkg: shared definitions for the UDP transmit-stream monitor.
// Holds the error-bit indices, the packet FSM state type, the header
// sideband struct and a saturating 16-bit length adder.
package udp_mon_pkg;

    localparam int unsigned ERR_VLD_DROP   = 0;
    localparam int unsigned ERR_PKT_CHANGE = 1;
    localparam int unsigned ERR_HDR_CHANGE = 2;
    localparam int unsigned ERR_KEEP_BAD   = 3;
    localparam int unsigned ERR_HDR_MIDPKT = 4;
    localparam int unsigned ERR_LEN_OVF    = 5;
    localparam int unsigned ERR_W          = 6;

    localparam int unsigned LEN_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } mon_state_t;

    typedef struct packed {
        logic [31:0] ip_dest;
        logic [31:0] ip_src;
        logic [15:0] port_dest;
        logic [15:0] port_src;
    } udp_hdr_t;

    // Packet length accumulation, clamped at all-ones.
    function automatic logic [LEN_W-1:0] len_sat_add(input logic [LEN_W-1:0] a,
                                                     input logic [LEN_W-1:0] b);
        logic [LEN_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[LEN_W] ? '1 : sum[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/udp_keep_check.sv
// udp_keep_check: combinational classifier for a tkeep vector.
// Ports:
//   keep       in   KEEP_W  byte enables, LSB = first byte
//   popcount   out  POP_W   number of enabled bytes
//   contiguous out  1       enabled bytes form an LSB-anchored run (or none)
//   all_ones   out  1       every byte enabled
//   zero       out  1       no byte enabled
module udp_keep_check #(
    parameter  int unsigned KEEP_W = 4,
    localparam int unsigned POP_W  = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [POP_W-1:0]  popcount,
    output logic              contiguous,
    output logic              all_ones,
    output logic              zero
);

    // Byte count of the beat.
    always_comb begin
        popcount = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            popcount = popcount + POP_W'(keep[i]);
        end
    end

    // A run 0..01..1 has no bit left set after adding one and masking.
    assign contiguous = ((keep & (keep + KEEP_W'(1))) == '0);
    assign all_ones   = (keep == '1);
    assign zero       = (keep == '0);

endmodule

// File: rtl/udp_stream_monitor.sv
// udp_stream_monitor: passive checker and statistics block for the UDP
// transmit stream (AXI-Stream beats plus IP/UDP header sideband).
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   ip_dest, ip_src, port_dest, port_src  header sideband (tapped)
//   tdata, tkeep, tlast, tvalid, tready   stream beat bus (tapped)
//   clear                              sync clear of counters/flags/packet state
//   err_flags                          sticky protocol error bits
//   err_pulse                          one-cycle pulse when an error bit newly sets
//   pkt_cnt, byte_cnt                  saturating accepted packet/byte counters
//   last_pkt_len, last_pkt_vld         length of latest packet and its strobe
// Build option: define UDP_STREAM_MONITOR_SVA_EN to add concurrent assertions.
module udp_stream_monitor
    import udp_mon_pkg::*;
#(
    parameter  int unsigned DATA_W        = 32,
    parameter  int unsigned MAX_PKT_BYTES = 1472,
    parameter  int unsigned CNT_W         = 32,
    localparam int unsigned KEEP_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       ip_dest,
    input  logic [31:0]       ip_src,
    input  logic [15:0]       port_dest,
    input  logic [15:0]       port_src,
    input  logic [DATA_W-1:0] tdata,
    input  logic [KEEP_W-1:0] tkeep,
    input  logic              tlast,
    input  logic              tvalid,
    input  logic              tready,
    input  logic              clear,
    output logic [ERR_W-1:0]  err_flags,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic [15:0]       last_pkt_len,
    output logic              last_pkt_vld
);

    localparam int unsigned POP_W = $clog2(KEEP_W + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_BYTES);

    udp_hdr_t           hdr_in;
    logic [POP_W-1:0]   k_pop;
    logic               k_contig;
    logic               k_all;
    logic               k_zero;

    mon_state_t         state_q,     state_d;
    udp_hdr_t           hdr_lat_q,   hdr_lat_d;
    logic [LEN_W-1:0]   run_len_q,   run_len_d;
    logic               snap_vld_q,  snap_vld_d;
    logic [DATA_W-1:0]  snap_data_q, snap_data_d;
    logic [KEEP_W-1:0]  snap_keep_q, snap_keep_d;
    logic               snap_last_q, snap_last_d;
    udp_hdr_t           snap_hdr_q,  snap_hdr_d;
    logic [ERR_W-1:0]   err_flags_q, err_flags_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   pkt_cnt_q,   pkt_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q,  byte_cnt_d;
    logic [LEN_W-1:0]   last_len_q,  last_len_d;
    logic               last_vld_q,  last_vld_d;

    logic               acc;
    logic               stall;
    logic [LEN_W-1:0]   base_len;
    logic [LEN_W-1:0]   new_len;
    logic [CNT_W:0]     byte_sum;
    logic [ERR_W-1:0]   err_new;

    assign hdr_in = {ip_dest, ip_src, port_dest, port_src};

    udp_keep_check #(.KEEP_W(KEEP_W)) u_keep_check (
        .keep       (tkeep),
        .popcount   (k_pop),
        .contiguous (k_contig),
        .all_ones   (k_all),
        .zero       (k_zero)
    );

    // Error detection, packet FSM, snapshot and statistics next-state.
    always_comb begin
        acc      = tvalid & tready;
        stall    = tvalid & ~tready;
        base_len = (state_q == IN_PKT) ? run_len_q : '0;
        new_len  = len_sat_add(base_len, LEN_W'(k_pop));
        byte_sum = {1'b0, byte_cnt_q} + (CNT_W + 1)'(k_pop);

        err_new                 = '0;
        err_new[ERR_VLD_DROP]   = snap_vld_q & ~tvalid;
        err_new[ERR_PKT_CHANGE] = snap_vld_q & tvalid &
                                  ({tdata, tkeep, tlast} != {snap_data_q, snap_keep_q, snap_last_q});
        err_new[ERR_HDR_CHANGE] = snap_vld_q & tvalid & (hdr_in != snap_hdr_q);
        err_new[ERR_KEEP_BAD]   = acc & (k_zero | ~k_contig | (~tlast & ~k_all));
        err_new[ERR_HDR_MIDPKT] = acc & (state_q == IN_PKT) & (hdr_in != hdr_lat_q);
        // Fires only on the beat that crosses the limit, so once per packet.
        err_new[ERR_LEN_OVF]    = acc & (new_len > MAX_LEN) & (base_len <= MAX_LEN);

        state_d     = state_q;
        hdr_lat_d   = hdr_lat_q;
        run_len_d   = run_len_q;
        snap_vld_d  = stall;
        snap_data_d = stall ? tdata  : snap_data_q;
        snap_keep_d = stall ? tkeep  : snap_keep_q;
        snap_last_d = stall ? tlast  : snap_last_q;
        snap_hdr_d  = stall ? hdr_in : snap_hdr_q;
        err_flags_d = err_flags_q | err_new;
        err_pulse_d = |(err_new & ~err_flags_q);
        pkt_cnt_d   = pkt_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        last_len_d  = last_len_q;
        last_vld_d  = 1'b0;

        if (acc) begin
            byte_cnt_d = byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
            if (tlast) begin
                pkt_cnt_d  = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + CNT_W'(1);
                last_len_d = new_len;
                last_vld_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!tlast) begin
                        state_d   = IN_PKT;
                        hdr_lat_d = hdr_in;
                        run_len_d = new_len;
                    end
                end
                IN_PKT: begin
                    run_len_d = tlast ? '0 : new_len;
                    if (tlast) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Clear overrides every event detected this cycle.
        if (clear) begin
            state_d     = IDLE;
            run_len_d   = '0;
            snap_vld_d  = 1'b0;
            err_flags_d = '0;
            err_pulse_d = 1'b0;
            pkt_cnt_d   = '0;
            byte_cnt_d  = '0;
            last_len_d  = '0;
            last_vld_d  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hdr_lat_q   <= '0;
            run_len_q   <= '0;
            snap_vld_q  <= 1'b0;
            snap_data_q <= '0;
            snap_keep_q <= '0;
            snap_last_q <= 1'b0;
            snap_hdr_q  <= '0;
            err_flags_q <= '0;
            err_pulse_q <= 1'b0;
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            last_len_q  <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_lat_q   <= hdr_lat_d;
            run_len_q   <= run_len_d;
            snap_vld_q  <= snap_vld_d;
            snap_data_q <= snap_data_d;
            snap_keep_q <= snap_keep_d;
            snap_last_q <= snap_last_d;
            snap_hdr_q  <= snap_hdr_d;
            err_flags_q <= err_flags_d;
            err_pulse_q <= err_pulse_d;
            pkt_cnt_q   <= pkt_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            last_len_q  <= last_len_d;
            last_vld_q  <= last_vld_d;
        end
    end

    assign err_flags    = err_flags_q;
    assign err_pulse    = err_pulse_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign byte_cnt     = byte_cnt_q;
    assign last_pkt_len = last_len_q;
    assign last_pkt_vld = last_vld_q;

`ifdef UDP_STREAM_MONITOR_SVA_EN
    // One assertion per protocol rule.
    for (genvar gi = 0; gi < int'(ERR_W); gi++) begin : g_sva
        a_err_bit: assert property (@(posedge clk) disable iff (!reset_n) !(err_new[gi] && !clear))
            else $error("udp_stream_monitor: protocol error bit %0d", gi);
    end

    a_data_w: assert property (@(posedge clk) (DATA_W % 8) == 0)
        else $error("udp_stream_monitor: DATA_W %0d is not a multiple of 8", DATA_W);
`endif

endmodule

// File: tb/tb_udp_stream_monitor.sv
// Self-checking bench for udp_stream_monitor (DATA_W=32). Packet lengths are
// pushed to a scoreboard queue when driven and popped on last_pkt_vld.
module tb_udp_stream_monitor;
    import udp_mon_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       ip_dest = 32'hC0A8_0001;
    logic [31:0]       ip_src = 32'hC0A8_0002;
    logic [15:0]       port_dest = 16'd1234;
    logic [15:0]       port_src = 16'd5678;
    logic [DATA_W-1:0] tdata = '0;
    logic [KEEP_W-1:0] tkeep = '0;
    logic              tlast = 1'b0;
    logic              tvalid = 1'b0;
    logic              tready = 1'b0;
    logic              clear = 1'b0;
    logic [ERR_W-1:0]  err_flags;
    logic              err_pulse;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [15:0]       last_pkt_len;
    logic              last_pkt_vld;

    always #5 clk = ~clk;

    udp_stream_monitor #(
        .DATA_W        (DATA_W),
        .MAX_PKT_BYTES (1472),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ip_dest      (ip_dest),
        .ip_src       (ip_src),
        .port_dest    (port_dest),
        .port_src     (port_src),
        .tdata        (tdata),
        .tkeep        (tkeep),
        .tlast        (tlast),
        .tvalid       (tvalid),
        .tready       (tready),
        .clear        (clear),
        .err_flags    (err_flags),
        .err_pulse    (err_pulse),
        .pkt_cnt      (pkt_cnt),
        .byte_cnt     (byte_cnt),
        .last_pkt_len (last_pkt_len),
        .last_pkt_vld (last_pkt_vld)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          pulse_cnt = 0;
    int          p0;
    int          stall_pct = 0;
    int unsigned exp_pkts = 0;
    int unsigned exp_bytes = 0;
    logic [16:0] exp_len_q[$];
    logic [16:0] mon_exp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare each reported packet length, count error pulses.
    always @(negedge clk) begin
        if (reset_n) begin
            if (last_pkt_vld) begin
                if (exp_len_q.size() != 0) mon_exp = exp_len_q.pop_front();
                else                       mon_exp = 17'h1_0000;
                check_eq("last_pkt_len", 64'(last_pkt_len), 64'(mon_exp));
            end
            if (err_pulse) pulse_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat, holding it through random stalls until accepted.
    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int   stalls = 0;
        logic acc;
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        do begin
            tready = (stalls < 8 && $urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
            acc    = tready;
            if (!tready) stalls++;
            step();
        end while (!acc);
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        tready = 1'b0;
        tlast  = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_pkt(input int len);
        int nb = (len + 3) / 4;
        int rem;
        exp_len_q.push_back(17'(len));
        exp_pkts++;
        exp_bytes += len;
        for (int b = 0; b < nb; b++) begin
            rem = (b == nb - 1) ? len - 4 * b : 4;
            beat($urandom, 4'((1 << rem) - 1), b == nb - 1);
        end
    endtask

    task automatic do_clear();
        tvalid = 1'b0;
        tready = 1'b0;
        clear  = 1'b1;
        step();
        clear     = 1'b0;
        exp_pkts  = 0;
        exp_bytes = 0;
    endtask

    // Stall one cycle with a fixed beat, then present the beat accepted.
    task automatic stall_once(input logic [31:0] d);
        tvalid = 1'b1;
        tready = 1'b0;
        tdata  = d;
        tkeep  = 4'hF;
        tlast  = 1'b1;
        step();
    endtask

    task automatic check_outs(input string tag, input logic [5:0] f);
        check_eq({tag, "_flags"}, 64'(err_flags), 64'(f));
        check_eq({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkts));
        check_eq({tag, "_byte_cnt"}, 64'(byte_cnt), 64'(exp_bytes));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 6'b000000);
        check_eq("reset_last_len", 64'(last_pkt_len), 64'd0);
        check_eq("reset_last_vld", 64'(last_pkt_vld), 64'd0);
        check_eq("reset_err_pulse", 64'(err_pulse), 64'd0);
        reset_n = 1'b1;
        step();

        // Clean traffic with random stalls.
        stall_pct = 30;
        send_pkt(8);
        send_pkt(5);
        send_pkt(1472);
        stall_pct = 0;
        idle(3);
        check_outs("clean", 6'b000000);
        check_eq("clean_byte_total", 64'(byte_cnt), 64'd1485);
        check_eq("clean_last_len", 64'(last_pkt_len), 64'd1472);
        check_eq("clean_pulses", 64'(pulse_cnt), 64'd0);

        // tvalid dropped after a stall.
        do_clear();
        p0 = pulse_cnt;
        stall_once(32'hDEAD_BEEF);
        tvalid = 1'b0;
        step();
        idle(3);
        check_outs("vld_drop", 6'b000001);
        check_eq("vld_drop_pulses", 64'(pulse_cnt - p0), 64'd1);

        // Data changes after a stall, then header changes after a stall.
        do_clear();
        p0 = pulse_cnt;
        stall_once(32'hDEAD_BEEF);
        exp_len_q.push_back(17'd4);
        exp_pkts++;
        exp_bytes += 4;
        tdata  = 32'hCAFE_F00D;
        tready = 1'b1;
        step();
        idle(2);
        check_outs("pkt_change", 6'b000010);
        port_dest = 16'd1234;
        stall_once(32'hDEAD_BEEF);
        exp_len_q.push_back(17'd4);
        exp_pkts++;
        exp_bytes += 4;
        port_dest = 16'd1235;
        tready    = 1'b1;
        step();
        idle(2);
        port_dest = 16'd1234;
        check_outs("hdr_change", 6'b000110);
        check_eq("change_pulses", 64'(pulse_cnt - p0), 64'd2);

        // Bad keep on a non-last and a last beat.
        do_clear();
        exp_len_q.push_back(17'd5);
        exp_pkts  = 1;
        exp_bytes = 5;
        beat(32'h1111_1111, 4'b0111, 1'b0);
        beat(32'h2222_2222, 4'b0101, 1'b1);
        idle(2);
        check_outs("keep_bad", 6'b001000);

        // Oversize packet: flag appears only after the 369th beat.
        do_clear();
        exp_len_q.push_back(17'd1476);
        exp_pkts  = 1;
        exp_bytes = 1476;
        for (int b = 0; b < 369; b++) begin
            beat($urandom, 4'hF, b == 368);
            if (b == 367) check_eq("ovf_early", 64'(err_flags[ERR_LEN_OVF]), 64'd0);
            if (b == 368) check_eq("ovf_set", 64'(err_flags[ERR_LEN_OVF]), 64'd1);
        end
        idle(2);
        check_outs("len_ovf", 6'b100000);
        check_eq("len_ovf_last_len", 64'(last_pkt_len), 64'd1476);

        // Header change inside a packet.
        do_clear();
        exp_len_q.push_back(17'd12);
        exp_pkts  = 1;
        exp_bytes = 12;
        beat(32'hA0A0_A0A0, 4'hF, 1'b0);
        ip_src = 32'hC0A8_0099;
        beat(32'hA1A1_A1A1, 4'hF, 1'b0);
        ip_src = 32'hC0A8_0002;
        beat(32'hA2A2_A2A2, 4'hF, 1'b1);
        idle(2);
        check_outs("hdr_midpkt", 6'b010000);

        // Clear in the middle of a packet.
        beat(32'hB0B0_B0B0, 4'hF, 1'b0);
        beat(32'hB1B1_B1B1, 4'hF, 1'b0);
        do_clear();
        check_outs("clear", 6'b000000);
        check_eq("clear_last_len", 64'(last_pkt_len), 64'd0);
        send_pkt(4);
        idle(2);
        check_outs("post_clear", 6'b000000);
        check_eq("post_clear_last_len", 64'(last_pkt_len), 64'd4);

        // Reset in the middle of a packet.
        beat(32'hC0C0_C0C0, 4'hF, 1'b0);
        beat(32'hC1C1_C1C1, 4'hF, 1'b0);
        tvalid  = 1'b0;
        tready  = 1'b0;
        reset_n = 1'b0;
        step();
        exp_pkts  = 0;
        exp_bytes = 0;
        check_outs("mid_reset", 6'b000000);
        check_eq("mid_reset_last_len", 64'(last_pkt_len), 64'd0);
        reset_n = 1'b1;
        step();
        send_pkt(4);
        idle(2);
        check_outs("post_reset", 6'b000000);
        check_eq("post_reset_last_len", 64'(last_pkt_len), 64'd4);

        check_eq("scoreboard_drained", 64'(exp_len_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/udp_stream_monitor.md
# udp_stream_monitor

Passive, parametrised protocol monitor for the UDP transmit stream (AXI-Stream beat bus plus IP/UDP header sideband). It taps any stream point between packet sources and the IP/UDP packer, never drives the bus, and turns every protocol rule into a synthesizable sticky error flag. It also maintains packet and byte statistics. It generalises the stream-interface assertions to any data width and adds packet-level checks, so the rules hold in silicon as well as in simulation.

## Interface
- DATA_W, 32: tdata width, multiple of 8, 8..512
- KEEP_W, DATA_W/8: tkeep width, derived, not overridable
- MAX_PKT_BYTES, 1472: largest legal UDP payload; must be ≤ 65535
- CNT_W, 32: statistics counter width
- clk  in  1  stream clock
- reset_n  in  1  asynchronous, active-low reset
- ip_dest, ip_src  in  32 each  header sideband
- port_dest, port_src  in  16 each  header sideband
- tdata  in  DATA_W  beat data
- tkeep  in  KEEP_W  byte enables, LSB = first byte
- tlast, tvalid, tready  in  1 each  stream handshake (tapped)
- clear  in  1  synchronous clear of counters, flags and packet state
- err_flags  out  6  sticky error bits, see Operation
- err_pulse  out  1  one-cycle pulse when any error bit sets this cycle
- pkt_cnt  out  CNT_W  accepted packets
- byte_cnt  out  CNT_W  accepted payload bytes
- last_pkt_len  out  16  byte length of most recent packet
- last_pkt_vld  out  1  one-cycle pulse with new last_pkt_len

## Operation
- Accepted beat: tvalid & tready. Stall: tvalid & ~tready. The stall snapshot holds tdata/tkeep/tlast and the header, registered on every stall cycle.
- err_flags bits:
  - [0] VLD_DROP: stall previous cycle and tvalid=0 now.
  - [1] PKT_CHANGE: stall previous cycle, tvalid now, and tdata/tkeep/tlast differ from the snapshot.
  - [2] HDR_CHANGE: same condition, header differs from the snapshot.
  - [3] KEEP_BAD: on an accepted beat, tkeep is zero, or not LSB-contiguous, or not all-ones while tlast=0.
  - [4] HDR_MIDPKT: on an accepted beat in IN_PKT, header differs from the header latched at the first beat.
  - [5] LEN_OVF: running packet length exceeds MAX_PKT_BYTES. Sets once per packet.
- FSM IDLE/IN_PKT:
  - IDLE→IN_PKT on accepted beat with tlast=0; latch header, run_len=popcount(tkeep).
  - IN_PKT: each accepted beat adds popcount(tkeep). tlast=1 → IDLE.
  - Single-beat packet (accepted with tlast=1 in IDLE) stays IDLE.
- On accepted tlast:
  - pkt_cnt += 1.
  - last_pkt_len = final run_len.
  - last_pkt_vld pulse.
- byte_cnt adds popcount(tkeep) on every accepted beat, including bad-keep beats.
- Counters saturate at all-ones. run_len saturates at 16'hFFFF.
- clear: counters, flags, run_len, FSM and snapshot valid bit go to zero/IDLE next edge. An error or count event in the clear cycle is discarded (clear wins).

## Timing
- Reset values: all outputs 0, FSM IDLE, snapshot invalid.
- Stall checks compare cycle N+1 against the stall at cycle N; the flag and err_pulse are visible at N+2.
- Beat checks (KEEP_BAD, HDR_MIDPKT, LEN_OVF) and counters: visible the cycle after the accepted beat.
- Back-to-back packets: tlast beat at N and first beat of the next packet at N+1 need no gap.
- A reset mid-packet abandons the packet. The next accepted beat starts a new packet.
- Latency is fixed; the block never asserts tready or tvalid.

## Configuration
- UDP_STREAM_MONITOR_SVA_EN defined: adds a concurrent assertion per error bit, each disabled iff !reset_n, reporting with $error, plus an assertion that DATA_W % 8 == 0.
- Undefined: flag logic only, fully synthesizable, no assertion code.

## Structure
- udp_mon_pkg holds:
  - localparam bit indices ERR_VLD_DROP..ERR_LEN_OVF, ERR_W=6
  - FSM enum mon_state_t {IDLE, IN_PKT}
  - header struct typedef (ip_dest, ip_src, port_dest, port_src)
- Sub-module udp_keep_check (combinational, parametrised on KEEP_W): outputs popcount, contiguous, all_ones, zero.

## Test plan
- Clean 3-packet traffic, DATA_W=32, lengths 8, 5 (tkeep 4'b0001 last), 1472, random stalls → err_flags=0, pkt_cnt=3, byte_cnt=1485, last_pkt_len=1472.
- Stall with tdata=0xDEADBEEF, then tvalid dropped for one cycle → err_flags=6'b000001, err_pulse high exactly once.
- Stall, then tdata changes to 0xCAFEF00D; separately port_dest changes 1234→1235 → bits [1] and [2] set.
- Non-last beat with tkeep=4'b0111; last beat with tkeep=4'b0101 → bit [3] set, byte_cnt still incremented by 3 and 2.
- 1476-byte packet → bit [5] set at the 369th beat, pkt_cnt increments, last_pkt_len=1476. ip_src changed mid-packet → bit [4].
- Assert clear and reset_n mid-packet: all outputs 0; the next 4-byte packet yields pkt_cnt=1, last_pkt_len=4.
